// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the RV32I writeback / PC-control stage.
package rv_wb_pkg;

    // Stage state: accepting instructions, or parked on an outstanding load.
    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    // funct3 value that marks ECALL/EBREAK/MRET (no CSR read-back).
    localparam logic [2:0] FUNCT3_PRIV = 3'b000;

    // Sequential instruction stride in bytes.
    localparam int PC_STEP = 4;

    // True for instruction classes that never write the register file.
    function automatic logic no_rd_write(
        input logic       is_branch,
        input logic       is_store,
        input logic       is_fence,
        input logic       is_system,
        input logic [2:0] funct3
    );
        return is_branch || is_store || is_fence ||
               (is_system && (funct3 == FUNCT3_PRIV));
    endfunction

endpackage

// File: rtl/rv_writeback_ctrl_if.sv
// Execute/memory-side bundle feeding the writeback stage.
interface rv_writeback_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [4:0]      rd_addr_in;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] csr_out;
    logic            go_to_trap;
    logic            return_from_trap;
    logic [XLEN-1:0] trap_address;
    logic [XLEN-1:0] return_address;
    logic            opcode_rtype;
    logic            opcode_itype;
    logic            opcode_load;
    logic            opcode_store;
    logic            opcode_branch;
    logic            opcode_jal;
    logic            opcode_jalr;
    logic            opcode_lui;
    logic            opcode_auipc;
    logic            opcode_system;
    logic            opcode_fence;
    logic            load_valid;
    logic            load_err;
    logic [XLEN-1:0] data_load;

    modport master (
        output in_valid, funct3, rd_addr_in, alu_out, imm, rs1, csr_out,
               go_to_trap, return_from_trap, trap_address, return_address,
               opcode_rtype, opcode_itype, opcode_load, opcode_store,
               opcode_branch, opcode_jal, opcode_jalr, opcode_lui,
               opcode_auipc, opcode_system, opcode_fence,
               load_valid, load_err, data_load,
        input  in_ready
    );

    modport slave (
        input  in_valid, funct3, rd_addr_in, alu_out, imm, rs1, csr_out,
               go_to_trap, return_from_trap, trap_address, return_address,
               opcode_rtype, opcode_itype, opcode_load, opcode_store,
               opcode_branch, opcode_jal, opcode_jalr, opcode_lui,
               opcode_auipc, opcode_system, opcode_fence,
               load_valid, load_err, data_load,
        output in_ready
    );

endinterface

// File: rtl/rv_instret_counter.sv
// Free-running event counter, wraps at 2^CNT_W; reused for cycle/mcycle.
module rv_instret_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per asserted inc, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/rv_writeback_ctrl.sv
// RV32I writeback / PC-control stage: computes rd, write strobe and next PC,
// parks on outstanding loads and flags redirects and retirements.
module rv_writeback_ctrl
    import rv_wb_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] PC_RESET     = '0,
    parameter int              CNT_W        = 64,
    parameter int              LOAD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_writeback_ctrl_if.slave bus,
    output logic [XLEN-1:0]   rd,
    output logic [4:0]        rd_addr,
    output logic              wr_rd,
    output logic [XLEN-1:0]   pc,
    output logic              redirect,
    output logic              retire,
    output logic              load_fault,
    output logic [CNT_W-1:0]  instret
);

    // Timeout counter holds 0..LOAD_TIMEOUT-1; the last value triggers a fault.
    localparam int              TO_W    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((LOAD_TIMEOUT > 0) ? (LOAD_TIMEOUT - 1) : 0);

    wb_state_e       state_r;
    logic [4:0]      ld_addr_r;
    logic [TO_W-1:0] to_cnt_r;

    logic [XLEN-1:0] pc_seq_s;
    logic [XLEN-1:0] add_sum_s;
    logic [XLEN-1:0] nxt_rd_s;
    logic [XLEN-1:0] nxt_pc_s;
    logic            nxt_wr_s;
    logic            nxt_retire_s;
    logic            load_park_s;
    logic            timeout_s;
    logic            retire_nxt_s;

    assign bus.in_ready = (state_r == ST_RUN);
    assign load_park_s  = bus.opcode_load && !bus.go_to_trap && !bus.return_from_trap;
    assign timeout_s    = (LOAD_TIMEOUT != 0) && (to_cnt_r == TO_LAST);

    // Next-state decode for an accepted instruction. Every general addition
    // is X+imm, so one adder with a pc/rs1 operand mux covers them all.
    always_comb begin
        pc_seq_s     = pc + XLEN'(PC_STEP);
        add_sum_s    = (bus.opcode_jalr ? bus.rs1 : pc) + bus.imm;
        nxt_rd_s     = rd;
        nxt_pc_s     = pc_seq_s;
        nxt_wr_s     = 1'b0;
        nxt_retire_s = 1'b0;
        if (bus.go_to_trap) begin
            nxt_pc_s = bus.trap_address;
        end else if (bus.return_from_trap) begin
            nxt_pc_s     = bus.return_address;
            nxt_retire_s = 1'b1;
        end else begin
            nxt_retire_s = 1'b1;
            nxt_wr_s     = (bus.rd_addr_in != 5'd0) &&
                           !no_rd_write(bus.opcode_branch, bus.opcode_store,
                                        bus.opcode_fence, bus.opcode_system, bus.funct3);
            if (bus.opcode_rtype || bus.opcode_itype) begin
                nxt_rd_s = bus.alu_out;
            end else if (bus.opcode_load) begin
                nxt_rd_s = bus.data_load;
            end else if (bus.opcode_branch) begin
                nxt_pc_s = bus.alu_out[0] ? add_sum_s : pc_seq_s;
            end else if (bus.opcode_jal) begin
                nxt_rd_s = pc_seq_s;
                nxt_pc_s = add_sum_s;
            end else if (bus.opcode_jalr) begin
                nxt_rd_s = pc_seq_s;
                nxt_pc_s = {add_sum_s[XLEN-1:1], 1'b0};
            end else if (bus.opcode_lui) begin
                nxt_rd_s = bus.imm;
            end else if (bus.opcode_auipc) begin
                nxt_rd_s = add_sum_s;
            end else if (bus.opcode_system && (bus.funct3 != FUNCT3_PRIV)) begin
                nxt_rd_s = bus.csr_out;
            end else begin
                nxt_pc_s = pc_seq_s;
            end
        end
    end

    // Retire qualifier, needed combinationally so instret moves with retire.
    always_comb begin
        retire_nxt_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.in_valid && !load_park_s) retire_nxt_s = nxt_retire_s;
                else                              retire_nxt_s = 1'b0;
            end
            ST_LOAD_WAIT: begin
                if (bus.load_valid && !bus.load_err) retire_nxt_s = 1'b1;
                else                                 retire_nxt_s = 1'b0;
            end
            default: retire_nxt_s = 1'b0;
        endcase
    end

    // Stage FSM with registered writeback, PC and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            ld_addr_r  <= 5'd0;
            to_cnt_r   <= '0;
            rd         <= '0;
            rd_addr    <= 5'd0;
            wr_rd      <= 1'b0;
            pc         <= PC_RESET;
            redirect   <= 1'b0;
            retire     <= 1'b0;
            load_fault <= 1'b0;
        end else begin
            wr_rd      <= 1'b0;
            redirect   <= 1'b0;
            load_fault <= 1'b0;
            retire     <= retire_nxt_s;
            case (state_r)
                ST_RUN: begin
                    if (bus.in_valid && load_park_s) begin
                        ld_addr_r <= bus.rd_addr_in;
                        to_cnt_r  <= '0;
                        state_r   <= ST_LOAD_WAIT;
                    end else if (bus.in_valid) begin
                        rd       <= nxt_rd_s;
                        rd_addr  <= bus.rd_addr_in;
                        wr_rd    <= nxt_wr_s;
                        pc       <= nxt_pc_s;
                        redirect <= (nxt_pc_s != pc_seq_s);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (bus.load_valid && !bus.load_err) begin
                        rd      <= bus.data_load;
                        rd_addr <= ld_addr_r;
                        wr_rd   <= (ld_addr_r != 5'd0);
                        pc      <= pc_seq_s;
                        state_r <= ST_RUN;
                    end else if (bus.load_valid || timeout_s) begin
                        load_fault <= 1'b1;
                        pc         <= bus.trap_address;
                        redirect   <= 1'b1;
                        state_r    <= ST_RUN;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                default: state_r <= ST_RUN;
            endcase
        end
    end

    rv_instret_counter #(.CNT_W(CNT_W)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_nxt_s),
        .count (instret)
    );

endmodule
